// File: rtl/regfile_2r2w_if.sv
// Operand-decode / write-back bus for regfile_2r2w.
// master drives the fetch and write-back side; slave is the register file.
interface regfile_2r2w_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              instr_valid;
  logic [15:0]       instr_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              spec_wr_en;
  logic [DATA_W-1:0] spec_wr_data;
  logic              out_valid;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              uses_spec;
  logic [DATA_W-1:0] spec_val;
  logic              wr_conflict;

  modport master (
    output instr_valid, instr_in, wr_en, wr_addr, wr_data, spec_wr_en, spec_wr_data,
    input  out_valid, opcode, op1, op2, uses_spec, spec_val, wr_conflict
  );

  modport slave (
    input  instr_valid, instr_in, wr_en, wr_addr, wr_data, spec_wr_en, spec_wr_data,
    output out_valid, opcode, op1, op2, uses_spec, spec_val, wr_conflict
  );
endinterface

// File: rtl/regfile_2r2w.sv
// Register file with registered two-operand decode, general and special-register write ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data into op1/op2 (default: read-before-write).
module regfile_2r2w #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned SPEC_IDX = 15,
  parameter bit          ZERO_R0  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  regfile_2r2w_if.slave bus
);
  localparam int unsigned       DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SPEC_A = ADDR_W'(SPEC_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] idx_a;
  logic [ADDR_W-1:0] idx_b;
  logic [3:0]        funct;
  logic              collide;
  logic              gen_wr;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign idx_a = bus.instr_in[8 +: ADDR_W];
  assign idx_b = bus.instr_in[4 +: ADDR_W];
  assign funct = bus.instr_in[3:0];

  // Secondary port owns SPEC_IDX: a colliding general write is dropped entirely.
  assign collide = bus.wr_en && bus.spec_wr_en && (bus.wr_addr == SPEC_A);
  assign gen_wr  = bus.wr_en && !collide && !(ZERO_R0 && (bus.wr_addr == '0));

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (gen_wr && (idx == bus.wr_addr))
      val = bus.wr_data;
    if (bus.spec_wr_en && (idx == SPEC_A))
      val = bus.spec_wr_data;
`endif
    if (ZERO_R0 && (idx == '0))
      val = '0;
    return val;
  endfunction

  always_comb begin
    rd_a = read_port(idx_a);
    rd_b = read_port(idx_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (gen_wr)
        regs[bus.wr_addr] <= bus.wr_data;
      if (bus.spec_wr_en)
        regs[SPEC_A] <= bus.spec_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.opcode      <= '0;
      bus.op1         <= '0;
      bus.op2         <= '0;
      bus.uses_spec   <= 1'b0;
      bus.wr_conflict <= 1'b0;
    end else begin
      bus.out_valid   <= bus.instr_valid;
      bus.wr_conflict <= collide;
      if (bus.instr_valid) begin
        bus.opcode    <= bus.instr_in[15:12];
        bus.op1       <= rd_a;
        bus.op2       <= rd_b;
        bus.uses_spec <= (bus.instr_in[15:12] == 4'hF) && ((funct == 4'h4) || (funct == 4'h5));
      end
    end
  end

  assign bus.spec_val = regs[SPEC_A];
endmodule

// File: tb/tb_regfile_2r2w.sv
// Self-checking bench for regfile_2r2w: directed vector table, reset/ADDR_W=3 sequences, random vs. model.
module tb_regfile_2r2w;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_2r2w_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  regfile_2r2w_if #(.DATA_W(16), .ADDR_W(3)) bus3 ();

  regfile_2r2w #(.DATA_W(16), .ADDR_W(4), .SPEC_IDX(15), .ZERO_R0(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  regfile_2r2w #(.DATA_W(16), .ADDR_W(3), .SPEC_IDX(7), .ZERO_R0(1'b1)) u3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  int errs = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [3:0] opc,
                           input logic [15:0] op1, input logic [15:0] op2, input logic us,
                           input logic conf, input logic [15:0] spec);
    check({tag, ".out_valid"},   16'(bus.out_valid),   16'(ov));
    check({tag, ".opcode"},      16'(bus.opcode),      16'(opc));
    check({tag, ".op1"},         bus.op1,              op1);
    check({tag, ".op2"},         bus.op2,              op2);
    check({tag, ".uses_spec"},   16'(bus.uses_spec),   16'(us));
    check({tag, ".wr_conflict"}, 16'(bus.wr_conflict), 16'(conf));
    check({tag, ".spec_val"},    bus.spec_val,         spec);
  endtask

  // Behavioural model: plain array of register contents plus expected output latches.
  logic [15:0] mdl [16];
  logic [15:0] e_op1, e_op2;
  logic [3:0]  e_opc;
  logic        e_us, e_ov, e_conf;

  function automatic logic [15:0] mread(input int idx, input logic conf);
    if (idx == 0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (bus.spec_wr_en && idx == 15) return bus.spec_wr_data;
    if (bus.wr_en && !conf && idx == int'(bus.wr_addr)) return bus.wr_data;
`endif
    return mdl[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    e_op1 = 16'h0; e_op2 = 16'h0; e_opc = 4'h0; e_us = 1'b0; e_ov = 1'b0; e_conf = 1'b0;
  endtask

  task automatic model_edge();
    logic conf;
    int a, b;
    conf = bus.wr_en && bus.spec_wr_en && (bus.wr_addr == 4'd15);
    a = int'(bus.instr_in[11:8]);
    b = int'(bus.instr_in[7:4]);
    if (bus.instr_valid) begin
      e_op1 = mread(a, conf);
      e_op2 = mread(b, conf);
      e_opc = bus.instr_in[15:12];
      e_us  = (bus.instr_in[15:12] == 4'hF) && (bus.instr_in[3:0] inside {4'h4, 4'h5});
    end
    e_ov   = bus.instr_valid;
    e_conf = conf;
    if (bus.wr_en && !conf && bus.wr_addr != 4'd0) mdl[bus.wr_addr] = bus.wr_data;
    if (bus.spec_wr_en) mdl[15] = bus.spec_wr_data;
  endtask

  task automatic cycle_model(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag, e_ov, e_opc, e_op1, e_op2, e_us, e_conf, mdl[15]);
  endtask

  typedef struct {
    logic        we;   logic [3:0]  wa;  logic [15:0] wd;
    logic        se;   logic [15:0] sd;
    logic        iv;   logic [15:0] ins;
    logic        ov;   logic [3:0]  opc; logic [15:0] op1; logic [15:0] op2;
    logic        us;   logic        conf; logic [15:0] spec;
  } vec_t;

`ifdef REGFILE_BYPASS_EN
  localparam logic [15:0] BYP7  = 16'h00FF;
  localparam logic [15:0] BYP15 = 16'h1234;
`else
  localparam logic [15:0] BYP7  = 16'h0000;
  localparam logic [15:0] BYP15 = 16'hCCCC;
`endif

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 4'd2,  16'h0050, 1'b0, 16'h0,    1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 4'd5,  16'h0040, 1'b0, 16'h0,    1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0,    1'b1, 16'hF254, 1'b1, 4'hF, 16'h0050, 16'h0040, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 4'd7,  16'h00FF, 1'b0, 16'h0,    1'b1, 16'h1700, 1'b1, 4'h1, BYP7,     16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0,    1'b1, 16'h1700, 1'b1, 4'h1, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 4'd15, 16'h1111, 1'b1, 16'hCCCC, 1'b0, 16'h0000, 1'b0, 4'h1, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'hCCCC};
    tbl[6]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0,    1'b0, 16'h0000, 1'b0, 4'h1, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hCCCC};
    tbl[7]  = '{1'b1, 4'd0,  16'hFFFF, 1'b0, 16'h0,    1'b0, 16'h0000, 1'b0, 4'h1, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hCCCC};
    tbl[8]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0,    1'b1, 16'h2000, 1'b1, 4'h2, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hCCCC};
    tbl[9]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 16'h1234, 1'b1, 16'h1F00, 1'b1, 4'h1, BYP15,    16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[10] = '{1'b1, 4'd15, 16'h5555, 1'b0, 16'h0,    1'b0, 16'h0000, 1'b0, 4'h1, BYP15,    16'h0000, 1'b0, 1'b0, 16'h5555};
    tbl[11] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0,    1'b1, 16'hF0F5, 1'b1, 4'hF, 16'h0000, 16'h5555, 1'b1, 1'b0, 16'h5555};

    reset = 1'b1;
    bus.instr_valid = 1'b0; bus.instr_in = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.spec_wr_en = 1'b0; bus.spec_wr_data = '0;
    bus3.instr_valid = 1'b0; bus3.instr_in = '0; bus3.wr_en = 1'b0; bus3.wr_addr = '0;
    bus3.wr_data = '0; bus3.spec_wr_en = 1'b0; bus3.spec_wr_data = '0;
    #1;
    check_all("por", 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      bus.wr_en = tbl[i].we; bus.wr_addr = tbl[i].wa; bus.wr_data = tbl[i].wd;
      bus.spec_wr_en = tbl[i].se; bus.spec_wr_data = tbl[i].sd;
      bus.instr_valid = tbl[i].iv; bus.instr_in = tbl[i].ins;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].opc, tbl[i].op1, tbl[i].op2,
                tbl[i].us, tbl[i].conf, tbl[i].spec);
    end

    // Asynchronous reset mid-cycle while a write to R3 is pending
    bus.spec_wr_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hABCD;
    bus.instr_valid = 1'b1; bus.instr_in = 16'h1300;
    @(posedge clk); #1;
    check("pre_rst.out_valid", 16'(bus.out_valid), 16'h1);
    #2 reset = 1'b1;
    #1;
    check_all("rst_async", 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(posedge clk); #1;
    check_all("rst_hold", 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    reset = 1'b0;
    model_reset();
    bus.wr_en = 1'b0;
    cycle_model("post_rst");
    check("post_rst.r3", bus.op1, 16'h0000);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.wr_en        = ($urandom_range(0, 3) != 0);
      bus.wr_addr      = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      bus.wr_data      = 16'($urandom);
      bus.spec_wr_en   = ($urandom_range(0, 3) == 0);
      bus.spec_wr_data = 16'($urandom);
      bus.instr_valid  = ($urandom_range(0, 3) != 0);
      bus.instr_in     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.instr_in[15:12] = 4'hF;
        bus.instr_in[3:0]   = 4'($urandom_range(3, 6));
      end
      cycle_model($sformatf("rnd%0d", n));
    end
    bus.wr_en = 1'b0; bus.spec_wr_en = 1'b0; bus.instr_valid = 1'b0;

    // ADDR_W = 3: index fields truncated to their low 3 bits
    bus3.wr_en = 1'b1; bus3.wr_addr = 3'd2; bus3.wr_data = 16'h0A0A;
    @(posedge clk); #1;
    bus3.wr_addr = 3'd1; bus3.wr_data = 16'h0B0B;
    @(posedge clk); #1;
    bus3.wr_en = 1'b0; bus3.instr_valid = 1'b1; bus3.instr_in = 16'h3A90;
    @(posedge clk); #1;
    check("a3.out_valid", 16'(bus3.out_valid), 16'h1);
    check("a3.opcode", 16'(bus3.opcode), 16'h3);
    check("a3.op1", bus3.op1, 16'h0A0A);
    check("a3.op2", bus3.op2, 16'h0B0B);
    bus3.instr_valid = 1'b0; bus3.instr_in = 16'h0000;
    @(posedge clk); #1;
    check("a3.idle_valid", 16'(bus3.out_valid), 16'h0);
    check("a3.op1_hold", bus3.op1, 16'h0A0A);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_2r2w.md
# regfile_2r2w

Parametrised register file and operand-decode stage for the 16-bit datapath. It decodes a 16-bit instruction into an opcode and two source operands, with one registered cycle of latency. It has a general write port plus a dedicated secondary write port for the special register, which holds the high result of multiply/divide. The block sits between instruction fetch and the ALU, and takes write-back from the final stage.

## Interface
Parameters:
- DATA_W, 16, register and operand width.
- ADDR_W, 4, register index width; depth = 2**ADDR_W; legal range 2..4.
- SPEC_IDX, 15, index of the special register written by the secondary port.
- ZERO_R0, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instr_in is valid this cycle.
- instr_in  in  16  instruction; [15:12] opcode, [8+ADDR_W-1:8] src A index, [4+ADDR_W-1:4] src B index, [3:0] funct.
- wr_en  in  1  general write enable.
- wr_addr  in  ADDR_W  general write index.
- wr_data  in  DATA_W  general write data.
- spec_wr_en  in  1  secondary write enable (always targets SPEC_IDX).
- spec_wr_data  in  DATA_W  secondary write data.
- out_valid  out  1  op1/op2/opcode/uses_spec are valid.
- opcode  out  4  registered opcode.
- op1  out  DATA_W  registered src A value.
- op2  out  DATA_W  registered src B value.
- uses_spec  out  1  instruction writes the special register (opcode 4'hF, funct 4'h4 or 4'h5).
- spec_val  out  DATA_W  current contents of register SPEC_IDX, continuously driven from storage.
- wr_conflict  out  1  one-cycle registered pulse: a general write to SPEC_IDX collided with a secondary write.

## Operation
- Reset (asynchronous): all registers clear to 0. op1, op2, spec_val = 0. opcode = 4'h0. out_valid, uses_spec, wr_conflict = 0.
- Decode, when instr_valid = 1:
  - op1 ← reg[src A] and op2 ← reg[src B].
  - opcode ← instr_in[15:12].
  - uses_spec ← (opcode == 4'hF) && (funct == 4'h4 || funct == 4'h5).
  - out_valid ← 1.
- When instr_valid = 0: out_valid ← 0; op1, op2, opcode and uses_spec hold their last values.
- General write: when wr_en = 1, reg[wr_addr] ← wr_data at the edge.
  - Ignored when ZERO_R0 = 1 and wr_addr = 0.
- Secondary write: when spec_wr_en = 1, reg[SPEC_IDX] ← spec_wr_data.
- Collision: if both wr_en = 1 and spec_wr_en = 1 and wr_addr = SPEC_IDX:
  - the secondary port wins and the general write is dropped;
  - wr_conflict = 1 for the next cycle, 0 otherwise.
- Simultaneous writes to different indices both commit.
- Reading index 0 with ZERO_R0 = 1 returns 0 regardless of stored state.
- Fields wider than ADDR_W bits are truncated: only the low ADDR_W bits of each 4-bit index field are used.

## Timing
- Decode latency: 1 cycle. instr_valid at edge N gives outputs valid after edge N (visible in cycle N+1).
- Write latency: 1 cycle. Data is in storage after the edge where the enable was sampled.
- Same-cycle read/write of one index is governed by the configuration macro below.
- spec_val reflects the storage content after the most recent edge.
- Reset mid-operation: all outputs and storage clear immediately. Writes pending in that cycle are discarded.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A same-cycle decode read of an index being written forwards the write data to op1/op2.
  - The secondary port has priority over the general port for SPEC_IDX.
  - The zeroed R0 is never forwarded.
- REGFILE_BYPASS_EN undefined: read-before-write. op1/op2 capture the pre-edge storage value, and the new value is seen by the next decode.

## Test plan
- Reset: assert reset mid-cycle with wr_en = 1 to R3 → all outputs 0 immediately. Read of R3 after release returns 16'h0000.
- Write R2 = 16'h0050 and R5 = 16'h0040, then decode 16'hF254 → next cycle: opcode = 4'hF, op1 = 16'h0050, op2 = 16'h0040, uses_spec = 1, out_valid = 1.
- Same-cycle wr_en to R7 = 16'h00FF with decode of 16'h1700 (R7 previously 0):
  - with REGFILE_BYPASS_EN → op1 = 16'h00FF;
  - without → op1 = 16'h0000, and a second decode returns 16'h00FF.
- wr_en to R15 = 16'h1111 and spec_wr_en = 16'hCCCC in the same cycle → spec_val = 16'hCCCC and wr_conflict pulses 1 for exactly one cycle.
- ZERO_R0 = 1: write R0 = 16'hFFFF, then decode 16'h2000 → op1 = 16'h0000.
- ADDR_W = 3: decode 16'h3A90 → src A index 2, src B index 1; instr_valid = 0 next cycle → out_valid = 0 and op1 holds.
